// File: rtl/msg_transmit_scheduler_if.sv
// ---------------------------------------------------------------------------
// msg_transmit_scheduler_if
//   Upstream FIFO write port shared by every channel of the transmit
//   scheduler.
//   wr_en      : write enable   (scheduler -> FIFO)
//   wr_dout    : write data     (scheduler -> FIFO)
//   prog_full  : programmable full flag (FIFO -> scheduler); it only holds
//                back the start of the next channel, never a running one.
//   master modport: scheduler side; slave modport: FIFO side.
// ---------------------------------------------------------------------------
interface msg_transmit_scheduler_if #(
  parameter int DW = 128
);
  logic          wr_en;
  logic [DW-1:0] wr_dout;
  logic          prog_full;

  modport master (
    output wr_en,
    output wr_dout,
    input  prog_full
  );

  modport slave (
    input  wr_en,
    input  wr_dout,
    output prog_full
  );
endinterface

// File: rtl/msg_transmit_scheduler.sv
// ---------------------------------------------------------------------------
// msg_transmit_scheduler
//   Sequences CH_NUM per-channel message drivers into one upstream FIFO.
//   A timing pulse snapshots the per-channel byte counts and builds the
//   pending set (enabled and non-empty channels). Pending channels are then
//   started one at a time in ascending index order. Each start waits for
//   room upstream, and each running channel is bounded by a watchdog.
//
//   Ports
//     sys_clk_i / rst_n_i    : clock, asynchronous active-low reset
//     timming_start_pluse_i  : one-cycle cycle-start pulse
//     ch_enable_i            : per-channel enable (sampled with the pulse)
//     data_count_i           : per-channel counts (sampled with the pulse)
//     drv_data_count_o       : latched count snapshot to the drivers
//     drv_start_o            : one-hot, one-cycle driver start
//     drv_done_i             : driver send-done pulses
//     drv_valid_i/drv_data_i : driver output words
//     frame_cnt_o            : completed-cycle counter
//     us_if                  : upstream FIFO write port (master)
//     busy_o                 : high whenever the scheduler is not idle
//     cycle_done_o           : one-cycle pulse at the end of a cycle
//     timeout_o/timeout_ch_o : watchdog expiry pulse / last expired channel
//     overrun_cnt_o          : saturating count of start pulses while busy
// ---------------------------------------------------------------------------
module msg_transmit_scheduler #(
  parameter int CH_NUM  = 25,
  parameter int DW      = 128,
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 65535
) (
  input  logic                    sys_clk_i,
  input  logic                    rst_n_i,
  input  logic                    timming_start_pluse_i,
  input  logic [CH_NUM-1:0]       ch_enable_i,
  input  logic [CH_NUM*CNT_W-1:0] data_count_i,
  output logic [CH_NUM*CNT_W-1:0] drv_data_count_o,
  output logic [CH_NUM-1:0]       drv_start_o,
  input  logic [CH_NUM-1:0]       drv_done_i,
  input  logic [CH_NUM-1:0]       drv_valid_i,
  input  logic [CH_NUM*DW-1:0]    drv_data_i,
  output logic [15:0]             frame_cnt_o,
  msg_transmit_scheduler_if.master us_if,
  output logic                    busy_o,
  output logic                    cycle_done_o,
  output logic                    timeout_o,
  output logic [7:0]              timeout_ch_o,
  output logic [7:0]              overrun_cnt_o
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int WD_W = 20;
  localparam logic [WD_W-1:0] TMO_LOAD = WD_W'(TMO_CYC);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SELECT    = 3'd1;
  localparam logic [2:0] WAIT_ROOM = 3'd2;
  localparam logic [2:0] START     = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] FINISH    = 3'd5;

  logic [2:0]              state_reg;
  logic [2:0]              state_next;
  logic [CH_NUM-1:0]       pending_reg;
  logic [CH_W-1:0]         cur_ch_reg;
  logic [WD_W-1:0]         wdog_reg;
  logic [15:0]             frame_cnt_reg;
  logic [7:0]              overrun_reg;
  logic [7:0]              timeout_ch_reg;
  logic [CH_NUM*CNT_W-1:0] count_snap_reg;
  logic [CH_NUM-1:0]       start_reg;
  logic                    busy_reg;
  logic                    cycle_done_reg;
  logic                    timeout_reg;
  logic                    wr_en_reg;
  logic [DW-1:0]           wr_dout_reg;

  logic [CH_NUM-1:0]       cnt_nz;
  logic [CH_NUM-1:0]       cur_onehot;
  logic [DW-1:0]           drv_word [CH_NUM];
  logic [CH_W-1:0]         low_idx;
  logic                    cur_done;
  logic                    cur_valid;
  logic [DW-1:0]           cur_data;
  logic                    wdog_expire;

  // Per-channel decode: non-empty flag, current-channel one-hot, word slice.
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign cnt_nz[gi]     = |data_count_i[gi*CNT_W +: CNT_W];
      assign cur_onehot[gi] = (cur_ch_reg == CH_W'(gi));
      assign drv_word[gi]   = drv_data_i[gi*DW +: DW];
    end
  endgenerate

  // Lowest pending index: scanning downward leaves the smallest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pending_reg[i]) low_idx = CH_W'(i);
    end
  end

  // Only the channel being served is looked at; strays from other channels
  // (including late dones from a timed-out channel) fall on the floor.
  assign cur_done    = drv_done_i[cur_ch_reg];
  assign cur_valid   = drv_valid_i[cur_ch_reg];
  assign cur_data    = drv_word[cur_ch_reg];
  // Expiring at 1 means exactly TMO_CYC cycles are spent in WAIT_DONE.
  assign wdog_expire = (wdog_reg == WD_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (timming_start_pluse_i) state_next = SELECT;
      SELECT:    state_next = (pending_reg == '0) ? FINISH : WAIT_ROOM;
      WAIT_ROOM: if (!us_if.prog_full) state_next = START;
      START:     state_next = cur_done ? SELECT : WAIT_DONE;
      WAIT_DONE: if (cur_done || wdog_expire) state_next = SELECT;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      cur_ch_reg     <= '0;
      wdog_reg       <= '0;
      frame_cnt_reg  <= '0;
      overrun_reg    <= '0;
      timeout_ch_reg <= '0;
      count_snap_reg <= '0;
      start_reg      <= '0;
      busy_reg       <= 1'b0;
      cycle_done_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_dout_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= (state_next != IDLE);
      start_reg      <= '0;
      cycle_done_reg <= 1'b0;
      timeout_reg    <= 1'b0;

      if (timming_start_pluse_i) begin
        if (state_reg == IDLE) begin
          count_snap_reg <= data_count_i;
          pending_reg    <= ch_enable_i & cnt_nz;
        end else if (overrun_reg != 8'hFF) begin
          overrun_reg <= overrun_reg + 8'd1;
        end
      end

      if (state_reg == SELECT) begin
        cur_ch_reg <= low_idx;
        if (pending_reg == '0) cycle_done_reg <= 1'b1;
      end

      // Start strobe, pending clear and watchdog load are registered on the
      // edge into START so the strobe is high exactly while in START.
      if (state_reg == WAIT_ROOM && !us_if.prog_full) begin
        start_reg   <= cur_onehot;
        pending_reg <= pending_reg & ~cur_onehot;
        wdog_reg    <= TMO_LOAD;
      end

      if (state_reg == WAIT_DONE && !cur_done) begin
        if (wdog_expire) begin
          timeout_reg    <= 1'b1;
          timeout_ch_reg <= {{(8-CH_W){1'b0}}, cur_ch_reg};
        end else begin
          wdog_reg <= wdog_reg - WD_W'(1);
        end
      end

      if (state_reg == FINISH) frame_cnt_reg <= frame_cnt_reg + 16'd1;

      // Upstream path: one register stage; the done-cycle word is included.
      if (state_reg == START || state_reg == WAIT_DONE) begin
        wr_en_reg   <= cur_valid;
        wr_dout_reg <= cur_data;
      end else begin
        wr_en_reg <= 1'b0;
      end
    end
  end

  assign drv_data_count_o = count_snap_reg;
  assign drv_start_o      = start_reg;
  assign frame_cnt_o      = frame_cnt_reg;
  assign busy_o           = busy_reg;
  assign cycle_done_o     = cycle_done_reg;
  assign timeout_o        = timeout_reg;
  assign timeout_ch_o     = timeout_ch_reg;
  assign overrun_cnt_o    = overrun_reg;
  assign us_if.wr_en      = wr_en_reg;
  assign us_if.wr_dout    = wr_dout_reg;

endmodule

// File: tb/tb_msg_transmit_scheduler.sv
module tb_msg_transmit_scheduler;
  localparam int CH  = 4;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pulse = 1'b0;
  logic [CH-1:0]     en = '0;
  logic [CH*CW-1:0]  cnt_in = '0;
  logic [CH*CW-1:0]  drv_cnt;
  logic [CH-1:0]     drv_start;
  logic [CH-1:0]     drv_done = '0;
  logic [CH-1:0]     drv_valid = '0;
  logic [CH*DW-1:0]  drv_data = '0;
  logic [15:0]       frame_cnt;
  logic              busy, cycle_done, timeout;
  logic [7:0]        timeout_ch, overrun;
  logic              hold_full = 1'b0;
  logic              bp_full = 1'b0;

  msg_transmit_scheduler_if #(.DW(DW)) us_if();
  assign us_if.prog_full = hold_full | bp_full;

  msg_transmit_scheduler #(.CH_NUM(CH), .DW(DW), .CNT_W(CW), .TMO_CYC(TMO)) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .timming_start_pluse_i(pulse),
    .ch_enable_i(en), .data_count_i(cnt_in), .drv_data_count_o(drv_cnt),
    .drv_start_o(drv_start), .drv_done_i(drv_done), .drv_valid_i(drv_valid),
    .drv_data_i(drv_data), .frame_cnt_o(frame_cnt), .us_if(us_if),
    .busy_o(busy), .cycle_done_o(cycle_done), .timeout_o(timeout),
    .timeout_ch_o(timeout_ch), .overrun_cnt_o(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int cd_cnt = 0, cd_cyc = 0, to_cnt = 0, to_cyc = 0;
  int rem [CH];
  int seq [CH];
  int done_cyc [CH];
  int bp_left = 0;
  logic [CH-1:0]   dead = '0;
  logic            bp_arm = 1'b0;
  logic [DW-1:0]   wq [$];
  logic [DW-1:0]   exp_w [$];
  logic [CH-1:0]   sq [$];
  int              scyc [$];

  function automatic logic [DW-1:0] mkw(input int c, input int s);
    return {8'hC5, 8'(c), 16'(s)};
  endfunction

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural drivers: on start, emit count words (one per cycle), done
  // with the last word unless the channel is marked dead.
  always @(negedge clk) begin
    drv_valid = '0;
    drv_done  = '0;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) rem[c] = 0;
      bp_left = 0;
      bp_full = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (drv_start[c]) begin
          rem[c] = int'(drv_cnt[c*CW +: CW]);
          seq[c] = 0;
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (rem[c] > 0) begin
          drv_valid[c] = 1'b1;
          drv_data[c*DW +: DW] = mkw(c, seq[c]);
          seq[c]++;
          rem[c]--;
          if (rem[c] == 0 && !dead[c]) begin
            drv_done[c] = 1'b1;
            done_cyc[c] = cyc;
            if (c == 0 && bp_arm) bp_left = 20;
          end
        end
      end
      if (bp_left > 0) begin
        bp_full = 1'b1;
        bp_left--;
      end else begin
        bp_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (us_if.wr_en) wq.push_back(us_if.wr_dout);
      if (drv_start != '0) begin
        sq.push_back(drv_start);
        scyc.push_back(cyc);
      end
      if (cycle_done) begin cd_cnt++; cd_cyc = cyc; end
      if (timeout) begin to_cnt++; to_cyc = cyc; end
    end
  end

  task automatic clr();
    wq.delete(); exp_w.delete(); sq.delete(); scyc.delete();
    cd_cnt = 0; to_cnt = 0;
  endtask

  task automatic add_exp(input int c, input int n);
    for (int s = 0; s < n; s++) exp_w.push_back(mkw(c, s));
  endtask

  // Mask and counts are scrambled right after the pulse: the DUT must keep
  // working from its snapshot.
  task automatic fire(input logic [CH-1:0] e, input int c0, input int c1, input int c2, input int c3);
    en = e;
    cnt_in = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    pulse = 1'b1;
    pulse_cyc = cyc + 1;
    @(negedge clk);
    pulse = 1'b0;
    en = ~e;
    cnt_in = {CH*CW{1'b1}};
  endtask

  task automatic wait_cd(input int budget);
    int n = 0;
    while (cd_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cd_cnt == 0) chk_val("cycle_done_wait", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_words(input string tag);
    chk_val({tag, "_nwords"}, wq.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
      chk_val($sformatf("%s_word%0d", tag, i), wq[i], exp_w[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_start", drv_start, 0);
    chk_val("rst_frame", frame_cnt, 0);
    chk_val("rst_overrun", overrun, 0);
    chk_val("rst_cycle_done", cycle_done, 0);
    chk_val("rst_wr_en", us_if.wr_en, 0);
    chk_val("rst_timeout_ch", timeout_ch, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep
    clr();
    fire(4'b1111, 2, 3, 1, 4);
    add_exp(0, 2); add_exp(1, 3); add_exp(2, 1); add_exp(3, 4);
    wait_cd(300);
    chk_val("sweep_snapshot", drv_cnt, 64'h0004_0001_0003_0002);
    chk_val("sweep_nstarts", sq.size(), 4);
    for (int i = 0; i < 4 && i < sq.size(); i++)
      chk_val($sformatf("sweep_start%0d", i), sq[i], 4'b0001 << i);
    if (scyc.size() >= 2) begin
      chk_val("sweep_first_latency", scyc[0] - pulse_cyc, 2);
      chk_val("sweep_gap", scyc[1] - done_cyc[0], 3);
    end
    chk_words("sweep");
    chk_val("sweep_cd_cnt", cd_cnt, 1);
    chk_val("sweep_frame", frame_cnt, 1);
    chk_val("sweep_busy", busy, 0);

    // Mask and empty skip
    clr();
    fire(4'b1011, 0, 5, 7, 2);
    add_exp(1, 5); add_exp(3, 2);
    wait_cd(300);
    chk_val("mask_nstarts", sq.size(), 2);
    if (sq.size() == 2) begin
      chk_val("mask_start0", sq[0], 4'b0010);
      chk_val("mask_start1", sq[1], 4'b1000);
    end
    chk_words("mask");
    chk_val("mask_frame", frame_cnt, 2);

    // Backpressure
    clr();
    bp_arm = 1'b1;
    fire(4'b0011, 2, 1, 0, 0);
    add_exp(0, 2); add_exp(1, 1);
    wait_cd(300);
    bp_arm = 1'b0;
    chk_val("bp_nstarts", sq.size(), 2);
    if (scyc.size() == 2) chk_val("bp_start_delay", scyc[1] - done_cyc[0], 21);
    chk_words("bp");

    // Timeout
    clr();
    dead = 4'b0100;
    fire(4'b1111, 1, 1, 1, 1);
    add_exp(0, 1); add_exp(1, 1); add_exp(2, 1); add_exp(3, 1);
    wait_cd(300);
    dead = '0;
    chk_val("tmo_nstarts", sq.size(), 4);
    chk_val("tmo_pulses", to_cnt, 1);
    if (scyc.size() >= 3) chk_val("tmo_latency", to_cyc - scyc[2], 17);
    chk_val("tmo_ch", timeout_ch, 2);
    chk_words("tmo");
    chk_val("tmo_cd_cnt", cd_cnt, 1);

    // Overrun, then frame counter wrap
    clr();
    hold_full = 1'b1;
    fire(4'b0001, 1, 0, 0, 0);
    add_exp(0, 1);
    for (int i = 0; i < 300; i++) begin
      pulse = 1'b1;
      @(negedge clk);
      pulse = 1'b0;
      @(negedge clk);
    end
    chk_val("ovr_count", overrun, 255);
    chk_val("ovr_busy", busy, 1);
    chk_val("ovr_no_start", sq.size(), 0);
    force dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_reg;
    @(negedge clk);
    hold_full = 1'b0;
    wait_cd(300);
    chk_val("wrap_frame", frame_cnt, 0);
    chk_words("wrap");

    // Empty pending set
    clr();
    fire(4'b0000, 3, 3, 3, 3);
    wait_cd(50);
    chk_val("empty_latency", cd_cyc - pulse_cyc, 1);
    chk_val("empty_nstarts", sq.size(), 0);
    chk_val("empty_frame", frame_cnt, 1);

    // Reset mid-cycle during channel 1
    clr();
    fire(4'b1111, 2, 8, 2, 2);
    for (int n = 0; n < 100 && sq.size() < 2; n++) @(negedge clk);
    chk_val("rstmid_reached_ch1", sq.size(), 2);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_val("rstmid_start", drv_start, 0);
    chk_val("rstmid_busy", busy, 0);
    chk_val("rstmid_wr_en", us_if.wr_en, 0);
    chk_val("rstmid_frame", frame_cnt, 0);
    chk_val("rstmid_overrun", overrun, 0);
    chk_val("rstmid_timeout_ch", timeout_ch, 0);
    chk_val("rstmid_snapshot", drv_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    fire(4'b0001, 3, 0, 0, 0);
    add_exp(0, 3);
    wait_cd(300);
    chk_val("fresh_nstarts", sq.size(), 1);
    if (sq.size() == 1) chk_val("fresh_start0", sq[0], 4'b0001);
    chk_words("fresh");
    chk_val("fresh_frame", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end
endmodule
